// File: rtl/seq_pattern_detector_pkg.sv
// Shared types and default sizing for the programmable sequence detector.
package seq_pattern_detector_pkg;

  localparam int unsigned DEF_MAX_LEN   = 8;
  localparam int unsigned DEF_CNT_WIDTH = 8;

  typedef enum logic {
    OUT_MOORE = 1'b0,
    OUT_MEALY = 1'b1
  } out_mode_e;

endpackage

// File: rtl/seq_pattern_detector_counter.sv
// Saturating match counter; clear has priority over increment.
module seq_pattern_detector_counter #(
  parameter int unsigned width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [width-1:0] count
);

  logic [width-1:0] count_q;
  logic [width-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// Runtime-programmable serial bit-pattern detector with Moore/Mealy output,
// optional overlapping matches and a saturating match counter.
module seq_pattern_detector
  import seq_pattern_detector_pkg::*;
#(
  parameter int unsigned max_len   = DEF_MAX_LEN,
  parameter int unsigned cnt_width = DEF_CNT_WIDTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic                           a,
  input  logic                           load,
  input  logic [max_len-1:0]             cfg_pattern,
  input  logic [$clog2(max_len+1)-1:0]   cfg_len,
  input  logic                           cfg_mealy,
  input  logic                           cfg_overlap,
  input  logic                           clr_count,
  output logic                           y,
  output logic [cnt_width-1:0]           match_count,
  output logic                           cfg_valid
);

  localparam int unsigned LEN_W = $clog2(max_len + 1);

  logic [max_len-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  out_mode_e          mode_q, mode_d;
  logic               overlap_q, overlap_d;
  logic               cfg_valid_q, cfg_valid_d;
  logic [max_len-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               y_q, y_d;

  logic [max_len-1:0] window_c;
  logic [max_len-1:0] mask_c;
  logic [LEN_W-1:0]   fill_inc_c;
  logic               primed_c;
  logic               hit_c;

  // Compare window: stored history plus the bit presented this cycle.
  always_comb begin
    window_c = {hist_q, a};
    for (int i = 0; i < int'(max_len); i++) begin
      mask_c[i] = (32'(i) < 32'(len_q));
    end
    primed_c   = ({1'b0, fill_q} + (LEN_W+1)'(1)) >= {1'b0, len_q};
    fill_inc_c = (fill_q < len_q) ? fill_q + LEN_W'(1) : len_q;
    hit_c      = en & ~load & cfg_valid_q & primed_c &
                 (((window_c ^ pattern_q) & mask_c) == '0);
  end

  always_comb begin
    pattern_d   = pattern_q;
    len_d       = len_q;
    mode_d      = mode_q;
    overlap_d   = overlap_q;
    cfg_valid_d = cfg_valid_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    y_d         = y_q;
    if (load) begin
      // Load drops any concurrent sample and restarts detection from scratch.
      pattern_d   = cfg_pattern;
      len_d       = cfg_len;
      mode_d      = out_mode_e'(cfg_mealy);
      overlap_d   = cfg_overlap;
      cfg_valid_d = (cfg_len != '0) && (32'(cfg_len) <= max_len);
      hist_d      = '0;
      fill_d      = '0;
      y_d         = 1'b0;
    end else if (en) begin
      hist_d = window_c[max_len-2:0];
      fill_d = (hit_c && !overlap_q) ? '0 : fill_inc_c;
      y_d    = hit_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_q   <= '0;
      len_q       <= '0;
      mode_q      <= OUT_MOORE;
      overlap_q   <= 1'b0;
      cfg_valid_q <= 1'b0;
      hist_q      <= '0;
      fill_q      <= '0;
      y_q         <= 1'b0;
    end else begin
      pattern_q   <= pattern_d;
      len_q       <= len_d;
      mode_q      <= mode_d;
      overlap_q   <= overlap_d;
      cfg_valid_q <= cfg_valid_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      y_q         <= y_d;
    end
  end

  seq_pattern_detector_counter #(
    .width (cnt_width)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (hit_c),
    .clr   (clr_count),
    .count (match_count)
  );

  assign y         = (mode_q == OUT_MEALY) ? hit_c : y_q;
  assign cfg_valid = cfg_valid_q;

endmodule
